// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x3 active-low matrix keypad and reports one
// debounced 4-bit key code per press, plus a strobe and a held-key level.
//
// Ports
//   clk      in   system clock, all logic on posedge
//   reset_1  in   asynchronous active-low reset
//   col_in   in   [2:0] keypad columns, active-low, asynchronous to clk
//   row_out  out  [3:0] keypad rows, active-low one-hot drive
//   Code_1   out  [3:0] code of the last accepted key, held until the next one
//   Valid_1  out  one VALID_LEN-cycle pulse per accepted press
//   S_Row    out  high while the accepted key is still held (debounced)
module keypad_scanner #(
    parameter int unsigned SCAN_DIV   = 1000,
    parameter int unsigned DEB_CYCLES = 20000,
    parameter int unsigned VALID_LEN  = 4
) (
    input  logic       clk,
    input  logic       reset_1,
    input  logic [2:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] Code_1,
    output logic       Valid_1,
    output logic       S_Row
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
    localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned VLD_W = (VALID_LEN > 1)  ? $clog2(VALID_LEN)  : 1;

    localparam logic [1:0] S_SCAN  = 2'd0;
    localparam logic [1:0] S_DEB_P = 2'd1;
    localparam logic [1:0] S_HELD  = 2'd2;
    localparam logic [1:0] S_DEB_R = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [1:0]       row_q, row_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DEB_W-1:0] deb_q, deb_d;
    logic [1:0]       cand_row_q, cand_row_d;
    logic [1:0]       cand_col_q, cand_col_d;
    logic [VLD_W-1:0] vld_cnt_q, vld_cnt_d;
    logic             vld_pend_q, vld_pend_d;
    logic [3:0]       code_d;
    logic             valid_d;
    logic             srow_d;
    logic [2:0]       col_meta, col_s;
    logic             cand_high_c;
    logic [1:0]       first_low_c;

    // Map (row, column) of the keypad to its key code.
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'b00_00: k = 4'd1;
            4'b00_01: k = 4'd2;
            4'b00_10: k = 4'd3;
            4'b01_00: k = 4'd4;
            4'b01_01: k = 4'd5;
            4'b01_10: k = 4'd6;
            4'b10_00: k = 4'd7;
            4'b10_01: k = 4'd8;
            4'b10_10: k = 4'd9;
            4'b11_00: k = 4'd10;
            4'b11_01: k = 4'd0;
            4'b11_10: k = 4'd11;
            default:  k = 4'd0;
        endcase
        return k;
    endfunction

    // Two-flop synchronizer for the asynchronous column lines (idle high).
    always_ff @(posedge clk or negedge reset_1) begin
        if (!reset_1) begin
            col_meta <= 3'b111;
            col_s    <= 3'b111;
        end else begin
            col_meta <= col_in;
            col_s    <= col_meta;
        end
    end

    // Level of the candidate key's column; only this column matters once a key is latched.
    always_comb begin
        case (cand_col_q)
            2'd0:    cand_high_c = col_s[0];
            2'd1:    cand_high_c = col_s[1];
            default: cand_high_c = col_s[2];
        endcase
    end

    // Lowest active column wins when several are pulled low.
    always_comb begin
        if (!col_s[0])      first_low_c = 2'd0;
        else if (!col_s[1]) first_low_c = 2'd1;
        else                first_low_c = 2'd2;
    end

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        div_d      = div_q;
        deb_d      = deb_q;
        cand_row_d = cand_row_q;
        cand_col_d = cand_col_q;
        vld_cnt_d  = vld_cnt_q;
        vld_pend_d = 1'b0;
        code_d     = Code_1;
        valid_d    = Valid_1;
        srow_d     = S_Row;

        // Pulse starts one cycle after the code update and runs to completion.
        if (vld_pend_q) begin
            valid_d   = 1'b1;
            vld_cnt_d = VLD_W'(VALID_LEN - 1);
        end else if (Valid_1) begin
            if (vld_cnt_q != '0) vld_cnt_d = vld_cnt_q - VLD_W'(1);
            else                 valid_d   = 1'b0;
        end

        case (state_q)
            S_SCAN: begin
                if (div_q == DIV_W'(SCAN_DIV - 1)) begin
                    div_d = '0;
                    if (col_s != 3'b111) begin
                        cand_row_d = row_q;
                        cand_col_d = first_low_c;
                        deb_d      = '0;
                        state_d    = S_DEB_P;
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_DEB_P: begin
                if (cand_high_c) begin
                    row_d   = row_q + 2'd1;
                    div_d   = '0;
                    state_d = S_SCAN;
                end else if (deb_q == DEB_W'(DEB_CYCLES - 1)) begin
                    code_d     = key_code(cand_row_q, cand_col_q);
                    vld_pend_d = 1'b1;
                    srow_d     = 1'b1;
                    state_d    = S_HELD;
                end else begin
                    deb_d = deb_q + DEB_W'(1);
                end
            end
            S_HELD: begin
                if (cand_high_c) begin
                    deb_d   = '0;
                    state_d = S_DEB_R;
                end
            end
            S_DEB_R: begin
                if (!cand_high_c) begin
                    deb_d   = '0;
                    state_d = S_HELD;
                end else if (deb_q == DEB_W'(DEB_CYCLES - 1)) begin
                    srow_d  = 1'b0;
                    row_d   = 2'd0;
                    div_d   = '0;
                    state_d = S_SCAN;
                end else begin
                    deb_d = deb_q + DEB_W'(1);
                end
            end
            default: state_d = S_SCAN;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_1) begin
        if (!reset_1) begin
            state_q    <= S_SCAN;
            row_q      <= 2'd0;
            div_q      <= '0;
            deb_q      <= '0;
            cand_row_q <= 2'd0;
            cand_col_q <= 2'd0;
            vld_cnt_q  <= '0;
            vld_pend_q <= 1'b0;
            row_out    <= 4'b1110;
            Code_1     <= 4'b0000;
            Valid_1    <= 1'b0;
            S_Row      <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            div_q      <= div_d;
            deb_q      <= deb_d;
            cand_row_q <= cand_row_d;
            cand_col_q <= cand_col_d;
            vld_cnt_q  <= vld_cnt_d;
            vld_pend_q <= vld_pend_d;
            row_out    <= ~(4'b0001 << row_d);
            Code_1     <= code_d;
            Valid_1    <= valid_d;
            S_Row      <= srow_d;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad model plus scenario tasks for keypad_scanner.
module tb_keypad_scanner;

    localparam int unsigned SCAN_DIV   = 4;
    localparam int unsigned DEB_CYCLES = 8;
    localparam int unsigned VALID_LEN  = 2;

    logic       clk;
    logic       reset_1;
    logic [2:0] col_in;
    logic [3:0] row_out;
    logic [3:0] Code_1;
    logic       Valid_1;
    logic       S_Row;

    // Keys indexed row*3+col: '1','2','3','4','5','6','7','8','9','#','0','*'
    logic [11:0] pressed;
    int          key_map [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};

    int n_cmp;
    int n_bad;

    // Pulse observer: records the code seen at each Valid_1 rise and pulse-shape defects.
    logic [3:0] pulse_q [$];
    int         bad_width;
    int         code_glitch;
    int         late_code;
    int         run_len;
    logic       prev_v;
    logic [3:0] rise_code;
    logic [3:0] prev_code;

    keypad_scanner #(
        .SCAN_DIV  (SCAN_DIV),
        .DEB_CYCLES(DEB_CYCLES),
        .VALID_LEN (VALID_LEN)
    ) dut (
        .clk    (clk),
        .reset_1(reset_1),
        .col_in (col_in),
        .row_out(row_out),
        .Code_1 (Code_1),
        .Valid_1(Valid_1),
        .S_Row  (S_Row)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Passive matrix: a pressed key shorts its column to its row when that row is driven low.
    always_comb begin
        col_in = 3'b111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (pressed[r*3+c] && row_out[r] === 1'b0) col_in[c] = 1'b0;
    end

    initial begin
        bad_width = 0; code_glitch = 0; late_code = 0; run_len = 0;
        prev_v = 1'b0; rise_code = 4'd0; prev_code = 4'd0;
    end

    always @(negedge clk) begin
        if (!reset_1) begin
            prev_v    = 1'b0;
            run_len   = 0;
            prev_code = Code_1;
        end else begin
            if (Valid_1 === 1'b1 && !prev_v) begin
                pulse_q.push_back(Code_1);
                rise_code = Code_1;
                run_len   = 1;
                if (prev_code !== Code_1) late_code++;
            end else if (Valid_1 === 1'b1) begin
                run_len++;
                if (Code_1 !== rise_code) code_glitch++;
            end else if (prev_v && run_len != int'(VALID_LEN)) begin
                bad_width++;
            end
            prev_v    = (Valid_1 === 1'b1);
            prev_code = Code_1;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        pressed = '0;
        reset_1 = 1'b1;
        #2 reset_1 = 1'b0;
        #1;
        n_cmp++; if (row_out !== 4'b1110) begin n_bad++; $display("FAIL reset_row_out got=%b exp=1110", row_out); end
        n_cmp++; if (Code_1 !== 4'b0000) begin n_bad++; $display("FAIL reset_code got=%b exp=0000", Code_1); end
        n_cmp++; if (Valid_1 !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", Valid_1); end
        n_cmp++; if (S_Row !== 1'b0) begin n_bad++; $display("FAIL reset_srow got=%b exp=0", S_Row); end
        cycles(3);
        reset_1 = 1'b1;
    endtask

    // With no key pressed each row is driven for SCAN_DIV cycles in order 0,1,2,3.
    task automatic test_rotation;
        logic [3:0] exp;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            exp = ~(4'b0001 << ((n / int'(SCAN_DIV)) % 4));
            n_cmp++;
            if (row_out !== exp) begin
                n_bad++; $display("FAIL rotation n=%0d got=%b exp=%b", n, row_out, exp);
            end
        end
    endtask

    task automatic test_press_5;
        int start, w;
        start = pulse_q.size();
        pressed[4] = 1'b1;
        w = 0;
        while (w < 60 && pulse_q.size() == start) begin @(negedge clk); w++; end
        n_cmp++; if (pulse_q.size() != start + 1) begin n_bad++; $display("FAIL press5_timeout pulses=%0d exp=%0d", pulse_q.size() - start, 1); end
        n_cmp++; if (w > 2 + 4*int'(SCAN_DIV) + int'(DEB_CYCLES) + 4) begin n_bad++; $display("FAIL press5_latency got=%0d max=%0d", w, 2 + 4*int'(SCAN_DIV) + int'(DEB_CYCLES) + 4); end
        n_cmp++; if (S_Row !== 1'b1) begin n_bad++; $display("FAIL press5_srow_held got=%b exp=1", S_Row); end
        cycles(60 - w);
        n_cmp++; if (Code_1 !== 4'b0101) begin n_bad++; $display("FAIL press5_code got=%b exp=0101", Code_1); end
        pressed[4] = 1'b0;
        cycles(4);
        n_cmp++; if (S_Row !== 1'b1) begin n_bad++; $display("FAIL press5_srow_release_deb got=%b exp=1", S_Row); end
        cycles(16);
        n_cmp++; if (S_Row !== 1'b0) begin n_bad++; $display("FAIL press5_srow_released got=%b exp=0", S_Row); end
        n_cmp++; if (pulse_q.size() != start + 1) begin n_bad++; $display("FAIL press5_pulse_count got=%0d exp=1", pulse_q.size() - start); end
        else begin
            n_cmp++; if (pulse_q[start] !== 4'b0101) begin n_bad++; $display("FAIL press5_pulse_code got=%b exp=0101", pulse_q[start]); end
        end
    endtask

    task automatic test_bounce_hash;
        int start;
        start = pulse_q.size();
        for (int i = 0; i < 8; i++) begin
            pressed[9] = ~pressed[9];
            cycles(3);
        end
        pressed[9] = 1'b1;
        cycles(60);
        pressed[9] = 1'b0;
        cycles(30);
        n_cmp++; if (pulse_q.size() != start + 1) begin n_bad++; $display("FAIL bounce_pulse_count got=%0d exp=1", pulse_q.size() - start); end
        else begin
            n_cmp++; if (pulse_q[start] !== 4'b1010) begin n_bad++; $display("FAIL bounce_pulse_code got=%b exp=1010", pulse_q[start]); end
        end
        n_cmp++; if (Code_1 !== 4'b1010) begin n_bad++; $display("FAIL bounce_code got=%b exp=1010", Code_1); end
    endtask

    task automatic test_short_7;
        int start;
        logic [3:0] seen;
        start = pulse_q.size();
        pressed[6] = 1'b1;
        cycles(5);
        pressed[6] = 1'b0;
        cycles(40);
        n_cmp++; if (pulse_q.size() != start) begin n_bad++; $display("FAIL short7_pulse got=%0d exp=0", pulse_q.size() - start); end
        n_cmp++; if (Code_1 !== 4'b1010) begin n_bad++; $display("FAIL short7_code got=%b exp=1010", Code_1); end
        seen = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            case (row_out)
                4'b1110: seen[0] = 1'b1;
                4'b1101: seen[1] = 1'b1;
                4'b1011: seen[2] = 1'b1;
                4'b0111: seen[3] = 1'b1;
                default: seen = '0;
            endcase
        end
        n_cmp++; if (seen !== 4'b1111) begin n_bad++; $display("FAIL short7_rotation rows_seen=%b exp=1111", seen); end
    endtask

    task automatic test_two_keys;
        int start;
        start = pulse_q.size();
        pressed[0] = 1'b1;
        cycles(40);
        pressed[8] = 1'b1;
        cycles(30);
        n_cmp++; if (pulse_q.size() != start + 1) begin n_bad++; $display("FAIL twokeys_first_count got=%0d exp=1", pulse_q.size() - start); end
        n_cmp++; if (Code_1 !== 4'b0001) begin n_bad++; $display("FAIL twokeys_held_code got=%b exp=0001", Code_1); end
        pressed[0] = 1'b0;
        cycles(3);
        pressed[8] = 1'b0;
        cycles(40);
        n_cmp++; if (pulse_q.size() != start + 1) begin n_bad++; $display("FAIL twokeys_after_release got=%0d exp=1", pulse_q.size() - start); end
        pressed[8] = 1'b1;
        cycles(50);
        pressed[8] = 1'b0;
        cycles(30);
        n_cmp++; if (pulse_q.size() != start + 2) begin n_bad++; $display("FAIL twokeys_total got=%0d exp=2", pulse_q.size() - start); end
        else begin
            n_cmp++; if (pulse_q[start] !== 4'b0001) begin n_bad++; $display("FAIL twokeys_code0 got=%b exp=0001", pulse_q[start]); end
            n_cmp++; if (pulse_q[start+1] !== 4'b1001) begin n_bad++; $display("FAIL twokeys_code1 got=%b exp=1001", pulse_q[start+1]); end
        end
    endtask

    task automatic test_sequence;
        int start;
        int keys [5] = '{1, 3, 2, 1, 9};
        start = pulse_q.size();
        foreach (keys[i]) begin
            pressed[keys[i]] = 1'b1;
            cycles(40);
            pressed[keys[i]] = 1'b0;
            cycles(20);
        end
        n_cmp++; if (pulse_q.size() != start + 5) begin n_bad++; $display("FAIL seq_count got=%0d exp=5", pulse_q.size() - start); end
        else begin
            foreach (keys[i]) begin
                n_cmp++;
                if (pulse_q[start+i] !== 4'(key_map[keys[i]])) begin
                    n_bad++; $display("FAIL seq_code idx=%0d got=%b exp=%b", i, pulse_q[start+i], 4'(key_map[keys[i]]));
                end
            end
        end
    endtask

    // Random presses with random holds, gaps and sub-debounce glitches on random keys.
    task automatic test_random;
        int start, k, g;
        logic [3:0] exp_q [$];
        start = pulse_q.size();
        for (int i = 0; i < 8; i++) begin
            k = int'($urandom_range(0, 11));
            pressed[k] = 1'b1;
            cycles(int'($urandom_range(40, 70)));
            pressed[k] = 1'b0;
            exp_q.push_back(4'(key_map[k]));
            cycles(int'($urandom_range(20, 30)));
            g = int'($urandom_range(0, 11));
            pressed[g] = 1'b1;
            cycles(int'($urandom_range(1, 6)));
            pressed[g] = 1'b0;
            cycles(20);
        end
        n_cmp++; if (pulse_q.size() != start + exp_q.size()) begin n_bad++; $display("FAIL random_count got=%0d exp=%0d", pulse_q.size() - start, exp_q.size()); end
        else begin
            foreach (exp_q[i]) begin
                n_cmp++;
                if (pulse_q[start+i] !== exp_q[i]) begin
                    n_bad++; $display("FAIL random_code idx=%0d got=%b exp=%b", i, pulse_q[start+i], exp_q[i]);
                end
            end
        end
        n_cmp++; if (Code_1 !== exp_q[exp_q.size()-1]) begin n_bad++; $display("FAIL random_final_code got=%b exp=%b", Code_1, exp_q[exp_q.size()-1]); end
    endtask

    task automatic test_reset_in_pulse;
        int start, w;
        pressed[7] = 1'b1;
        w = 0;
        while (w < 60 && Valid_1 !== 1'b1) begin @(negedge clk); w++; end
        n_cmp++; if (Valid_1 !== 1'b1) begin n_bad++; $display("FAIL rstpulse_timeout valid=%b exp=1", Valid_1); end
        #2 reset_1 = 1'b0;
        #1;
        n_cmp++; if (row_out !== 4'b1110) begin n_bad++; $display("FAIL rstpulse_row got=%b exp=1110", row_out); end
        n_cmp++; if (Code_1 !== 4'b0000) begin n_bad++; $display("FAIL rstpulse_code got=%b exp=0000", Code_1); end
        n_cmp++; if (Valid_1 !== 1'b0) begin n_bad++; $display("FAIL rstpulse_valid got=%b exp=0", Valid_1); end
        n_cmp++; if (S_Row !== 1'b0) begin n_bad++; $display("FAIL rstpulse_srow got=%b exp=0", S_Row); end
        pressed[7] = 1'b0;
        cycles(3);
        reset_1 = 1'b1;
        start = pulse_q.size();
        cycles(50);
        n_cmp++; if (pulse_q.size() != start) begin n_bad++; $display("FAIL rstpulse_no_valid got=%0d exp=0", pulse_q.size() - start); end
        n_cmp++; if (Code_1 !== 4'b0000) begin n_bad++; $display("FAIL rstpulse_code_after got=%b exp=0000", Code_1); end
    endtask

    // A key held straight through reset is picked up again as a fresh press.
    task automatic test_reset_held_key;
        int start;
        pressed[5] = 1'b1;
        cycles(45);
        n_cmp++; if (S_Row !== 1'b1) begin n_bad++; $display("FAIL rstheld_srow_before got=%b exp=1", S_Row); end
        reset_1 = 1'b0;
        cycles(2);
        reset_1 = 1'b1;
        start = pulse_q.size();
        cycles(40);
        n_cmp++; if (pulse_q.size() != start + 1) begin n_bad++; $display("FAIL rstheld_count got=%0d exp=1", pulse_q.size() - start); end
        else begin
            n_cmp++; if (pulse_q[start] !== 4'b0110) begin n_bad++; $display("FAIL rstheld_code got=%b exp=0110", pulse_q[start]); end
        end
        pressed[5] = 1'b0;
        cycles(30);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_rotation();
        test_press_5();
        test_bounce_hash();
        test_short_7();
        test_two_keys();
        test_sequence();
        test_random();
        test_reset_in_pulse();
        test_reset_held_key();
        n_cmp++; if (bad_width != 0) begin n_bad++; $display("FAIL pulse_width bad_pulses=%0d exp=0", bad_width); end
        n_cmp++; if (code_glitch != 0) begin n_bad++; $display("FAIL code_stable_in_pulse changes=%0d exp=0", code_glitch); end
        n_cmp++; if (late_code != 0) begin n_bad++; $display("FAIL code_before_valid late=%0d exp=0", late_code); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
